// File: rtl/spike_rate_monitor_if.sv
// Bundle of neuron-side sample inputs and the valid/ready result port of spike_rate_monitor.
// slave: the monitor side; master: the producer/consumer side driving it.
interface spike_rate_monitor_if #(
  parameter int unsigned WINDOW_W = 8,
  parameter int unsigned COUNT_W  = 8,
  parameter int unsigned U_W      = 4
);
  logic                ena;
  logic                spike_in;
  logic [U_W-1:0]      u_in;
  logic [WINDOW_W-1:0] window_len;
  logic                out_valid;
  logic                out_ready;
  logic [COUNT_W-1:0]  out_count;
  logic [U_W-1:0]      out_u_max;
  logic                out_sat;
  logic                out_lost;

  modport master (
    output ena, spike_in, u_in, window_len, out_ready,
    input  out_valid, out_count, out_u_max, out_sat, out_lost
  );

  modport slave (
    input  ena, spike_in, u_in, window_len, out_ready,
    output out_valid, out_count, out_u_max, out_sat, out_lost
  );
endinterface

// File: rtl/spike_rate_monitor.sv
// Windowed spike counter with peak membrane tracking and a single-entry valid/ready result register.
// Define SPIKE_MON_UMAX_EN to build the peak-u tracking; otherwise out_u_max is tied to 0.
module spike_rate_monitor #(
  parameter int unsigned WINDOW_W = 8,
  parameter int unsigned COUNT_W  = 8,
  parameter int unsigned U_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spike_rate_monitor_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [WINDOW_W-1:0] len_q, len_d;
  logic [WINDOW_W-1:0] idx_q, idx_d;
  logic [WINDOW_W-1:0] len_cur, last_idx;
  logic [COUNT_W-1:0]  acc_q, acc_d, cnt_n;
  logic                sat_q, sat_d, sat_n;
  logic                last, emit, hs, acc_full;

  logic                vld_q, vld_d;
  logic                lost_q, lost_d;
  logic                osat_q, osat_d;
  logic [COUNT_W-1:0]  ocnt_q, ocnt_d;

`ifdef SPIKE_MON_UMAX_EN
  logic [U_W-1:0]      umax_q, umax_d, umax_n;
  logic [U_W-1:0]      ou_q, ou_d;
`else
  logic                unused_u;
  assign unused_u = ^bus.u_in;
`endif

  // Window sequencing and result-register next state
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    vld_d   = vld_q;
    lost_d  = lost_q;
    ocnt_d  = ocnt_q;
    osat_d  = osat_q;

    // Length 0 wraps to all-ones, i.e. 2^WINDOW_W samples
    len_cur  = (state_q == RUN) ? len_q : bus.window_len;
    last_idx = len_cur - WINDOW_W'(1);
    last     = (idx_q == last_idx);
    acc_full = (acc_q == {COUNT_W{1'b1}});
    cnt_n    = (bus.spike_in && !acc_full) ? acc_q + COUNT_W'(1) : acc_q;
    sat_n    = sat_q | (acc_full & bus.spike_in);
    emit     = bus.ena & last;
    hs       = vld_q & bus.out_ready;

`ifdef SPIKE_MON_UMAX_EN
    umax_d = umax_q;
    ou_d   = ou_q;
    umax_n = ((state_q == IDLE) || (idx_q == '0) || (bus.u_in > umax_q)) ? bus.u_in : umax_q;
`endif

    if (bus.ena) begin
      if (last) begin
        state_d = RUN;
        len_d   = bus.window_len;
        idx_d   = '0;
        acc_d   = '0;
        sat_d   = 1'b0;
`ifdef SPIKE_MON_UMAX_EN
        umax_d  = '0;
`endif
      end else begin
        acc_d = cnt_n;
        sat_d = sat_n;
        idx_d = idx_q + WINDOW_W'(1);
`ifdef SPIKE_MON_UMAX_EN
        umax_d = umax_n;
`endif
        if (state_q == IDLE) begin
          state_d = RUN;
          len_d   = bus.window_len;
        end
      end
    end

    // A handshake on the emitting edge frees the slot, so that emission never drops
    if (emit) begin
      if (!vld_q || hs) begin
        vld_d  = 1'b1;
        ocnt_d = cnt_n;
        osat_d = sat_n;
`ifdef SPIKE_MON_UMAX_EN
        ou_d   = umax_n;
`endif
      end else begin
        lost_d = 1'b1;
      end
    end else if (hs) begin
      vld_d = 1'b0;
    end
    if (hs) begin
      lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      vld_q   <= 1'b0;
      lost_q  <= 1'b0;
      ocnt_q  <= '0;
      osat_q  <= 1'b0;
`ifdef SPIKE_MON_UMAX_EN
      umax_q  <= '0;
      ou_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      vld_q   <= vld_d;
      lost_q  <= lost_d;
      ocnt_q  <= ocnt_d;
      osat_q  <= osat_d;
`ifdef SPIKE_MON_UMAX_EN
      umax_q  <= umax_d;
      ou_q    <= ou_d;
`endif
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_count = ocnt_q;
  assign bus.out_sat   = osat_q;
  assign bus.out_lost  = lost_q;
`ifdef SPIKE_MON_UMAX_EN
  assign bus.out_u_max = ou_q;
`else
  assign bus.out_u_max = '0;
`endif

endmodule
